// File: rtl/ahci_dma_rd_realign.sv
// AHCI DMA read realign: drops leading words of the first beat, packs 16-bit words
// into little-endian dwords with half-word mask and last marker, buffers them in a FWFT FIFO.
module ahci_dma_rd_realign #(
    parameter int unsigned IN_WORDS   = 4,
    parameter int unsigned WCNT_BITS  = 21,
    parameter int unsigned DEPTH_BITS = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [WCNT_BITS-1:0]          wcnt,
    input  logic [$clog2(IN_WORDS)-1:0]   woffs,
    input  logic                          abort,
    input  logic [16*IN_WORDS-1:0]        din,
    input  logic                          din_av,
    output logic                          din_re,
    output logic                          busy,
    output logic                          done,
    output logic [31:0]                   dout,
    output logic [1:0]                    dout_dm,
    output logic                          dout_last,
    output logic                          dout_vld,
    input  logic                          dout_re,
    output logic [DEPTH_BITS:0]           fifo_cnt
);

    localparam int unsigned OW    = $clog2(IN_WORDS);
    localparam int unsigned SW    = $clog2(IN_WORDS + 2);
    localparam int unsigned LW    = WCNT_BITS + 1;
    localparam int unsigned SBITS = 16 * (IN_WORDS + 1);
    localparam int unsigned DEPTH = 1 << DEPTH_BITS;
    localparam int unsigned PW    = DEPTH_BITS + 1;

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_DRAIN} state_t;

    typedef struct packed {
        logic        last;
        logic [1:0]  dm;
        logic [31:0] data;
    } entry_t;

    state_t            state_q, state_n;
    logic [LW-1:0]     in_left_q, in_left_n;
    logic              first_q, first_n;
    logic [OW-1:0]     skip_q, skip_n;
    logic [SBITS-1:0]  stage_q, stage_n;
    logic [SW-1:0]     stage_cnt_q, stage_cnt_n;
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    entry_t            mem [DEPTH];
    entry_t            wentry, head;

    logic full, push_two, push_pad, push, last_push, pop, room;

    assign busy     = (state_q != S_IDLE);
    assign fifo_cnt = wr_ptr_q - rd_ptr_q;
    assign dout_vld = (wr_ptr_q != rd_ptr_q);
    assign full     = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {DEPTH_BITS{1'b0}}});
    assign pop      = dout_re & dout_vld;

    // A dword leaves staging when two words are present, or one word once the input is exhausted.
    assign push_two  = (stage_cnt_q >= SW'(2));
    assign push_pad  = (stage_cnt_q == SW'(1)) && (in_left_q == '0);
    assign push      = !full && !abort && (push_two || push_pad);
    assign last_push = push && (in_left_q == '0) && (push_pad || stage_cnt_q == SW'(2));
    assign done      = last_push;
    assign room      = push ? (stage_cnt_q <= SW'(3)) : (stage_cnt_q <= SW'(1));
    assign din_re    = busy && din_av && (in_left_q != '0) && room && !abort;

    assign wentry.last = last_push;
    assign wentry.dm   = push_pad ? 2'b01 : 2'b11;
    assign wentry.data = push_pad ? {16'h0000, stage_q[15:0]} : stage_q[31:0];

    assign head      = mem[rd_ptr_q[DEPTH_BITS-1:0]];
    assign dout      = dout_vld ? head.data : '0;
    assign dout_dm   = dout_vld ? head.dm   : '0;
    assign dout_last = dout_vld ? head.last : 1'b0;

    always_comb begin
        state_n = state_q;
        case (state_q)
            S_IDLE:  if (start && !abort) state_n = S_XFER;
            S_XFER:  if (abort) state_n = S_IDLE;
                     else if (last_push) state_n = S_DRAIN;
            S_DRAIN: if (abort || (pop && fifo_cnt == PW'(1))) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Staging update: drop popped words, then append the valid words of an accepted beat.
    always_comb begin
        int popped, rc, sidx, avail, take;
        logic [SBITS-1:0]        shifted, keep, tmask;
        logic [16*IN_WORDS-1:0]  din_sh;
        popped      = 0;
        rc          = 0;
        sidx        = 0;
        avail       = 0;
        take        = 0;
        shifted     = '0;
        keep        = '0;
        tmask       = '0;
        din_sh      = '0;
        in_left_n   = in_left_q;
        first_n     = first_q;
        skip_n      = skip_q;
        stage_n     = stage_q;
        stage_cnt_n = stage_cnt_q;
        if (abort) begin
            in_left_n   = '0;
            first_n     = 1'b0;
            skip_n      = '0;
            stage_n     = '0;
            stage_cnt_n = '0;
        end else if (state_q == S_IDLE) begin
            if (start) begin
                in_left_n = LW'(wcnt) + LW'(1);
                skip_n    = woffs;
                first_n   = 1'b1;
            end
        end else begin
            popped = push ? (push_pad ? 1 : 2) : 0;
            rc     = int'(stage_cnt_q) - popped;
            sidx   = first_q ? int'(skip_q) : 0;
            avail  = int'(IN_WORDS) - sidx;
            if (din_re) take = (int'(in_left_q) < avail) ? int'(in_left_q) : avail;
            shifted     = stage_q >> (16 * popped);
            keep        = (SBITS'(1) << (16 * rc)) - SBITS'(1);
            din_sh      = din >> (16 * sidx);
            tmask       = (SBITS'(1) << (16 * take)) - SBITS'(1);
            stage_n     = (shifted & keep) | ((SBITS'(din_sh) & tmask) << (16 * rc));
            stage_cnt_n = SW'(rc + take);
            in_left_n   = in_left_q - LW'(take);
            first_n     = first_q & ~din_re;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_left_q   <= '0;
            first_q     <= 1'b0;
            skip_q      <= '0;
            stage_q     <= '0;
            stage_cnt_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_n;
            in_left_q   <= in_left_n;
            first_q     <= first_n;
            skip_q      <= skip_n;
            stage_q     <= stage_n;
            stage_cnt_q <= stage_cnt_n;
            wr_ptr_q    <= abort ? '0 : wr_ptr_q + PW'(push);
            rd_ptr_q    <= abort ? '0 : rd_ptr_q + PW'(pop);
        end
    end

    // FIFO storage; outputs are masked by dout_vld so no reset is needed here.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q[DEPTH_BITS-1:0]] <= wentry;
    end

endmodule

// File: tb/tb_ahci_dma_rd_realign.sv
// Directed bench for ahci_dma_rd_realign: scoreboard of expected dwords built from the
// word stream, popped and compared as the FIFO head is consumed.
module tb_ahci_dma_rd_realign;

    localparam int unsigned IW = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, abort, din_av, din_re, busy, done, dout_last, dout_vld, dout_re;
    logic [20:0]  wcnt;
    logic [1:0]   woffs;
    logic [63:0]  din;
    logic [31:0]  dout;
    logic [1:0]   dout_dm;
    logic [3:0]   fifo_cnt;

    logic         s8_start, s8_abort, s8_din_av, s8_din_re, s8_busy, s8_done;
    logic         s8_dout_last, s8_dout_vld, s8_dout_re;
    logic [20:0]  s8_wcnt;
    logic [2:0]   s8_woffs;
    logic [127:0] s8_din;
    logic [31:0]  s8_dout;
    logic [1:0]   s8_dout_dm;
    logic [3:0]   s8_fifo_cnt;

    logic [63:0]  beat_q[$];
    logic [34:0]  exp_q[$];
    int           checks = 0, passed = 0, done_cnt = 0, dre_cnt = 0;

    always #5 clk = ~clk;

    ahci_dma_rd_realign #(.IN_WORDS(4), .WCNT_BITS(21), .DEPTH_BITS(3)) u_dut (
        .clk(clk), .rst(rst), .start(start), .wcnt(wcnt), .woffs(woffs), .abort(abort),
        .din(din), .din_av(din_av), .din_re(din_re), .busy(busy), .done(done),
        .dout(dout), .dout_dm(dout_dm), .dout_last(dout_last), .dout_vld(dout_vld),
        .dout_re(dout_re), .fifo_cnt(fifo_cnt));

    ahci_dma_rd_realign #(.IN_WORDS(8), .WCNT_BITS(21), .DEPTH_BITS(3)) u_dut8 (
        .clk(clk), .rst(rst), .start(s8_start), .wcnt(s8_wcnt), .woffs(s8_woffs),
        .abort(s8_abort), .din(s8_din), .din_av(s8_din_av), .din_re(s8_din_re),
        .busy(s8_busy), .done(s8_done), .dout(s8_dout), .dout_dm(s8_dout_dm),
        .dout_last(s8_dout_last), .dout_vld(s8_dout_vld), .dout_re(s8_dout_re),
        .fifo_cnt(s8_fifo_cnt));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic apply_din();
        din_av = (beat_q.size() != 0);
        din    = din_av ? beat_q[0] : 64'h0;
    endtask

    // Queue beats carrying words base+0.. and the dwords the transfer should produce.
    task automatic load(input int offs, input int cnt, input logic [15:0] base, input int extra);
        int nbeats;
        logic [63:0] bt;
        logic [15:0] lo;
        nbeats = (offs + cnt + IW) / IW;
        for (int b = 0; b < nbeats + extra; b++) begin
            for (int k = 0; k < IW; k++) bt[16*k +: 16] = base + 16'(b * IW + k);
            beat_q.push_back(bt);
        end
        for (int i = 0; i <= cnt; i += 2) begin
            lo = base + 16'(offs + i);
            if (i < cnt) exp_q.push_back({(i + 1 == cnt), 2'b11, base + 16'(offs + i + 1), lo});
            else         exp_q.push_back({1'b1, 2'b01, 16'h0000, lo});
        end
        apply_din();
    endtask

    // One clock: sample settled outputs, score pops, advance to the next falling edge.
    task automatic tick();
        logic [63:0] bt;
        #1;
        if (din_re) begin
            dre_cnt++;
            bt = beat_q.pop_front();
        end
        if (done) done_cnt++;
        if (dout_vld && dout_re) begin
            chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0)
                chk("dword", 64'({dout_last, dout_dm, dout}), 64'(exp_q.pop_front()));
        end
        @(negedge clk);
        apply_din();
    endtask

    task automatic start_xfer(input int offs, input int cnt);
        done_cnt = 0;
        dre_cnt  = 0;
        woffs    = 2'(offs);
        wcnt     = 21'(cnt);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic run_done(input int maxc);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < maxc) begin
            tick();
            n++;
        end
        chk("xfer_complete", 64'({busy, exp_q.size() != 0}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, got, beats8, done8;
        rst = 1'b1; start = 1'b0; abort = 1'b0; wcnt = '0; woffs = '0;
        din = '0; din_av = 1'b0; dout_re = 1'b0;
        s8_start = 1'b0; s8_abort = 1'b0; s8_wcnt = '0; s8_woffs = '0;
        s8_din = '0; s8_din_av = 1'b0; s8_dout_re = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs", 64'({busy, done, din_re, dout_vld, dout_last, dout_dm, dout, fifo_cnt}), 64'd0);
        chk("reset_outputs8", 64'({s8_busy, s8_dout_vld, s8_fifo_cnt}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // aligned 8-word transfer
        dout_re = 1'b1;
        load(0, 7, 16'h0000, 1);
        start_xfer(0, 7);
        chk("busy_after_start", 64'(busy), 64'd1);
        run_done(100);
        chk("done_pulses_aligned", 64'(done_cnt), 64'd1);
        chk("beats_aligned", 64'(dre_cnt), 64'd2);
        chk("unused_beat_left", 64'(beat_q.size()), 64'd1);
        beat_q.delete(); apply_din();

        // offset 3, three words, padded tail
        load(3, 2, 16'h0000, 1);
        start_xfer(3, 2);
        run_done(100);
        chk("done_pulses_offs3", 64'(done_cnt), 64'd1);
        chk("beats_offs3", 64'(dre_cnt), 64'd2);
        beat_q.delete(); apply_din();

        // single word at offset 1 and at the last offset
        load(1, 0, 16'h0000, 1);
        start_xfer(1, 0);
        run_done(100);
        chk("beats_single", 64'(dre_cnt), 64'd1);
        beat_q.delete(); apply_din();
        load(3, 0, 16'h0050, 0);
        start_xfer(3, 0);
        run_done(100);
        chk("done_single_last_off", 64'(done_cnt), 64'd1);

        // FIFO fill with back-pressure, start ignored while busy, then drain
        dout_re = 1'b0;
        load(0, 39, 16'h0200, 0);
        start_xfer(0, 39);
        repeat (40) tick();
        #1;
        chk("fifo_full_cnt", 64'(fifo_cnt), 64'd8);
        chk("din_re_stalled", 64'(din_re), 64'd0);
        woffs = 2'd2; wcnt = 21'd3; start = 1'b1;
        tick();
        start = 1'b0;
        dout_re = 1'b1;
        run_done(300);
        chk("done_pulses_full", 64'(done_cnt), 64'd1);
        chk("beats_full", 64'(dre_cnt), 64'd10);

        // abort with five dwords queued
        dout_re = 1'b0;
        load(0, 39, 16'h0300, 0);
        start_xfer(0, 39);
        n = 0;
        while (fifo_cnt != 4'd5 && n < 50) begin tick(); n++; end
        chk("fifo_five_queued", 64'(fifo_cnt), 64'd5);
        abort = 1'b1;
        #1;
        chk("din_re_in_abort", 64'(din_re), 64'd0);
        tick();
        abort = 1'b0;
        chk("after_abort", 64'({dout_vld, fifo_cnt, busy}), 64'd0);
        chk("no_done_on_abort", 64'(done_cnt), 64'd0);
        exp_q.delete(); beat_q.delete(); apply_din();
        dout_re = 1'b1;
        load(1, 4, 16'h0400, 0);
        start_xfer(1, 4);
        run_done(100);
        chk("done_after_abort", 64'(done_cnt), 64'd1);

        // 128-bit input variant of the aligned transfer
        for (int k = 0; k < 8; k++) s8_din[16*k +: 16] = 16'(k);
        s8_wcnt = 21'd7; s8_woffs = 3'd0; s8_dout_re = 1'b1; s8_din_av = 1'b1; s8_start = 1'b1;
        n = 0; got = 0; beats8 = 0; done8 = 0;
        while (got < 4 && n < 40) begin
            #1;
            if (s8_din_re) beats8++;
            if (s8_done) done8++;
            if (s8_dout_vld) begin
                chk("dword8", 64'({s8_dout_last, s8_dout_dm, s8_dout}),
                    64'({(got == 3), 2'b11, 16'(2 * got + 1), 16'(2 * got)}));
                got++;
            end
            @(negedge clk);
            s8_start = 1'b0;
            if (beats8 != 0) s8_din_av = 1'b0;
            n++;
        end
        chk("dwords8_count", 64'(got), 64'd4);
        chk("beats8", 64'(beats8), 64'd1);
        chk("done8", 64'(done8), 64'd1);
        chk("busy8_idle", 64'(s8_busy), 64'd0);

        // asynchronous reset in the middle of a transfer
        dout_re = 1'b0;
        load(0, 39, 16'h0500, 0);
        start_xfer(0, 39);
        repeat (6) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset", 64'({busy, din_re, dout_vld, dout_last, dout_dm, dout, fifo_cnt}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete(); beat_q.delete(); apply_din();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
